// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO with one-cycle registered read
// latency and re-presents its words on a valid/ready stream through a 3-entry
// skid buffer. The FIFO read request never depends on the consumer's ready.
module fifo_stream_reader #(
    parameter type         T     = logic [31:0],
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_fifo_empty,
    input  T                 i_fifo_read_data,
    output logic             o_fifo_read_en,
    input  logic             i_flush,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output T                 o_out_data,
    output logic [CNT_W-1:0] o_rd_count
);

    localparam int unsigned DEPTH = 3;
    localparam int unsigned PTR_W = 2;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PART  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    T                 r_buf [0:DEPTH-1];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W-1:0] r_occ;
    logic             r_infl;
    logic [CNT_W-1:0] r_rd_count;

    logic             w_read_en;
    logic             w_capture;
    logic             w_pop;
    logic [PTR_W-1:0] w_head_inc;
    logic [PTR_W-1:0] w_tail_inc;
    logic [PTR_W-1:0] w_occ_next;
    state_t           w_state_next;

    // Read request: room for the buffered plus in-flight words, never tied to out_ready.
    assign w_read_en = !i_reset && !i_fifo_empty && !i_flush &&
                       (({1'b0, r_occ} + {2'b00, r_infl}) < 3'(DEPTH));

    assign w_capture = r_infl && !i_flush;
    assign w_pop     = (r_state != S_EMPTY) && i_out_ready && !i_flush;

    assign w_head_inc = (r_head == PTR_W'(DEPTH - 1)) ? '0 : r_head + PTR_W'(1);
    assign w_tail_inc = (r_tail == PTR_W'(DEPTH - 1)) ? '0 : r_tail + PTR_W'(1);

    // Occupancy bookkeeping: capture and pop together leave occ unchanged.
    always_comb begin
        w_occ_next = r_occ;
        if (w_capture && !w_pop) begin
            w_occ_next = r_occ + PTR_W'(1);
        end else if (!w_capture && w_pop) begin
            w_occ_next = r_occ - PTR_W'(1);
        end
    end

    // Map occupancy onto the EMPTY / PART / FULL state encoding.
    always_comb begin
        w_state_next = S_PART;
        if (w_occ_next == '0) begin
            w_state_next = S_EMPTY;
        end else if (w_occ_next == PTR_W'(DEPTH)) begin
            w_state_next = S_FULL;
        end
    end

    // Skid buffer, pointers, in-flight flag and delivered-word counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_EMPTY;
            r_head     <= '0;
            r_tail     <= '0;
            r_occ      <= '0;
            r_infl     <= 1'b0;
            r_rd_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_buf[i] <= '0;
            end
        end else if (i_flush) begin
            // Buffered and in-flight words are discarded; the count is kept.
            r_state <= S_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
            r_infl  <= 1'b0;
        end else begin
            r_infl  <= w_read_en;
            r_occ   <= w_occ_next;
            r_state <= w_state_next;
            if (w_capture) begin
                r_buf[r_tail] <= i_fifo_read_data;
                r_tail        <= w_tail_inc;
            end
            if (w_pop) begin
                r_head     <= w_head_inc;
                r_rd_count <= r_rd_count + CNT_W'(1);
            end
        end
    end

    assign o_fifo_read_en = w_read_en;
    assign o_out_valid    = (r_state != S_EMPTY);
    assign o_out_data     = r_buf[r_head];
    assign o_rd_count     = r_rd_count;

endmodule
